// File: rtl/lockstep_pkg.sv
// Shared types and limits for the lockstep checker: FSM state encoding and
// the largest supported channel count and reference latency.
package lockstep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    CHECK  = 2'd2,
    HALT   = 2'd3
  } state_t;

  localparam int MAX_NCH = 8;
  localparam int MAX_LAT = 7;

endpackage

// File: rtl/lsc_delay.sv
// Fixed-depth delay line that aligns reference-side data with the late DUT data.
// DEPTH = 0 degenerates to a wire.
module lsc_delay #(
  parameter int DW    = 1,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q = d;
  end else begin : g_pipe
    logic [DW-1:0] stage [DEPTH];

    // NOTE: every stage is reset so a freshly reset checker never compares
    // against stale reference data; this is a shift register, not a RAM.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
        // NOTE: non-blocking assignments let every stage sample the old value
        // of its predecessor, so the chain shifts by exactly one per clock.
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/lockstep_checker.sv
// Lockstep checker: compares a delayed golden-model stream against DUT outputs
// per channel, keeps a sticky verdict, first-failure capture and counters.
module lockstep_checker
  import lockstep_pkg::*;
#(
  parameter int NCH          = 2,
  parameter int W            = 5,
  parameter int LAT          = 1,
  parameter int WARM         = 1,
  parameter int CW           = 8,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [NCH-1:0]   cond,
  input  logic [NCH*W-1:0] ref_data,
  input  logic [NCH*W-1:0] dut_data,
  output logic [NCH-1:0]   mismatch,
  output logic             fail,
  output logic [2:0]       fail_chan,
  output logic [W-1:0]     fail_ref,
  output logic [W-1:0]     fail_dut,
  output logic [CW-1:0]    err_count,
  output logic [CW-1:0]    chk_count,
  output logic [1:0]       state
);

  localparam int DW   = NCH * (W + 1);
  localparam int WTOT = (WARM + LAT > 0) ? WARM + LAT : 1;
  localparam int WCW  = $clog2(WTOT + 1);
  localparam int SW   = ((CW > 4) ? CW : 4) + 1;
  localparam logic [SW-1:0] CMAX = (SW'(1) << CW) - SW'(1);

  state_t             state_q, state_d;
  logic [WCW-1:0]     warm_cnt;
  logic               warm_done;
  logic [DW-1:0]      dly_q;
  logic [NCH-1:0]     cond_d;
  logic [NCH*W-1:0]   ref_d;
  logic               cmp_en, any_cmp;
  logic [NCH-1:0]     fail_vec;
  logic [3:0]         n_fail;
  logic [2:0]         first_idx;
  logic [W-1:0]       first_ref, first_dut;
  logic [SW-1:0]      err_sum;
  logic [CW-1:0]      err_next;

  lsc_delay #(.DW(DW), .DEPTH(LAT)) u_delay (
    .clk (clk),
    .rst (rst),
    .d   ({cond, ref_data}),
    .q   (dly_q)
  );
  assign {cond_d, ref_d} = dly_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Counts cycles spent in WARMUP; restarts on every entry, including via clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           warm_cnt <= '0;
    else if (state_q != WARMUP || clr) warm_cnt <= '0;
    else                               warm_cnt <= warm_cnt + WCW'(1);
  end
  assign warm_done = (warm_cnt == WCW'(WTOT - 1));

  always_comb begin
    state_d = state_q;
    if (clr)      state_d = en ? WARMUP : IDLE;
    else if (!en) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    state_d = WARMUP;
        WARMUP:  if (warm_done) state_d = CHECK;
        CHECK:   if (STOP_ON_FAIL != 0 && |fail_vec) state_d = HALT;
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Walking from the top channel down leaves the lowest failing index captured.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves
    // one unassigned, which would otherwise infer a latch.
    fail_vec  = '0;
    n_fail    = '0;
    first_idx = '0;
    first_ref = '0;
    first_dut = '0;
    cmp_en    = (state_q == CHECK) && en;
    any_cmp   = cmp_en && (|cond_d);
    for (int i = NCH - 1; i >= 0; i--) begin
      if (cmp_en && cond_d[i] && (ref_d[i*W +: W] != dut_data[i*W +: W])) begin
        fail_vec[i] = 1'b1;
        n_fail      = n_fail + 4'd1;
        first_idx   = 3'(i);
        first_ref   = ref_d[i*W +: W];
        first_dut   = dut_data[i*W +: W];
      end
    end
    err_sum  = SW'(err_count) + SW'(n_fail);
    err_next = (err_sum > CMAX) ? '1 : err_sum[CW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      mismatch  <= '0;
      fail      <= 1'b0;
      fail_chan <= '0;
      fail_ref  <= '0;
      fail_dut  <= '0;
      err_count <= '0;
      chk_count <= '0;
    end else begin
      mismatch  <= fail_vec;
      err_count <= err_next;
      if (|fail_vec && !fail) begin
        fail      <= 1'b1;
        fail_chan <= first_idx;
        fail_ref  <= first_ref;
        fail_dut  <= first_dut;
      end
      if (any_cmp && chk_count != '1) chk_count <= chk_count + CW'(1);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_lockstep_checker.sv
// Self-checking bench: one halting checker (defaults) and one free-running
// checker with 3-bit counters, driven from the same stimulus.
module tb_lockstep_checker;

  logic       clk = 1'b0;
  logic       rst, en, clr;
  logic [1:0] cond;
  logic [9:0] ref_data, dut_data;

  logic [1:0] mm_a, mm_b, st_a, st_b;
  logic       fail_a, fail_b;
  logic [2:0] fch_a, fch_b;
  logic [4:0] fref_a, fref_b, fdut_a, fdut_b;
  logic [7:0] err_a, cc_a;
  logic [2:0] err_b, cc_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] q_a[$];
  logic [1:0] q_b[$];
  logic [1:0] prev_cond = 2'b00;
  logic [9:0] prev_ref  = 10'd0;
  int exp_err_a = 0, exp_err_b = 0, exp_cc_a = 0, exp_cc_b = 0;

  always #5 clk = ~clk;

  lockstep_checker u_a (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .cond(cond),
    .ref_data(ref_data), .dut_data(dut_data), .mismatch(mm_a), .fail(fail_a),
    .fail_chan(fch_a), .fail_ref(fref_a), .fail_dut(fdut_a),
    .err_count(err_a), .chk_count(cc_a), .state(st_a)
  );

  lockstep_checker #(.CW(3), .STOP_ON_FAIL(0)) u_b (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .cond(cond),
    .ref_data(ref_data), .dut_data(dut_data), .mismatch(mm_b), .fail(fail_b),
    .fail_chan(fch_b), .fail_ref(fref_b), .fail_dut(fdut_b),
    .err_count(err_b), .chk_count(cc_b), .state(st_b)
  );

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // One clock of stimulus. chk_x says whether checker x is comparing on this
  // edge; the expected mismatch is derived from the bench's own one-cycle
  // copy of cond/ref, pushed to the scoreboard and popped after the edge.
  task automatic step(input logic [1:0] c, input logic [9:0] r, input logic [9:0] d,
                      input bit chk_a, input bit chk_b);
    logic [1:0] raw, ea, eb, got_a, got_b;
    raw = prev_cond & {prev_ref[9:5] != d[9:5], prev_ref[4:0] != d[4:0]};
    ea  = (chk_a && !clr) ? raw : 2'b00;
    eb  = (chk_b && !clr) ? raw : 2'b00;
    q_a.push_back(ea);
    q_b.push_back(eb);
    if (clr) begin
      exp_err_a = 0; exp_err_b = 0; exp_cc_a = 0; exp_cc_b = 0;
    end else begin
      if (chk_a) begin
        exp_err_a = sat(exp_err_a + int'(ea[0]) + int'(ea[1]), 255);
        if (prev_cond != 2'b00) exp_cc_a = sat(exp_cc_a + 1, 255);
      end
      if (chk_b) begin
        exp_err_b = sat(exp_err_b + int'(eb[0]) + int'(eb[1]), 7);
        if (prev_cond != 2'b00) exp_cc_b = sat(exp_cc_b + 1, 7);
      end
    end
    cond = c; ref_data = r; dut_data = d;
    @(posedge clk);
    prev_cond = c;
    prev_ref  = r;
    @(negedge clk);
    got_a = q_a.pop_front();
    got_b = q_b.pop_front();
    if (mm_a !== got_a) begin n_fail++; $display("FAIL mismatch_a: got %b expected %b", mm_a, got_a); end
    n_checks++;
    if (mm_b !== got_b) begin n_fail++; $display("FAIL mismatch_b: got %b expected %b", mm_b, got_b); end
    n_checks++;
  endtask

  function automatic logic [9:0] rnd();
    return 10'($urandom);
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0;
    cond = '0; ref_data = '0; dut_data = '0;
    @(negedge clk); @(negedge clk);
    if ({st_a, mm_a, fail_a, fch_a, fref_a, fdut_a, err_a, cc_a} !== '0) begin
      n_fail++; $display("FAIL reset_a: got %h expected 0", {st_a, mm_a, fail_a, fch_a, fref_a, fdut_a, err_a, cc_a});
    end
    n_checks++;
    if ({st_b, mm_b, fail_b, fch_b, fref_b, fdut_b, err_b, cc_b} !== '0) begin
      n_fail++; $display("FAIL reset_b: got %h expected 0", {st_b, mm_b, fail_b, fch_b, fref_b, fdut_b, err_b, cc_b});
    end
    n_checks++;
    rst = 1'b0;
    en  = 1'b1;
  endtask

  // 20 cycles from WARMUP entry: 2 warm-up cycles then 18 compares.
  task automatic test_pass();
    logic [1:0] exp_st;
    for (int i = 0; i < 21; i++) begin
      step(2'b11, rnd(), prev_ref, i >= 3, i >= 3);
      exp_st = (i < 2) ? 2'd1 : 2'd2;
      if (st_a !== exp_st) begin n_fail++; $display("FAIL pass_state[%0d]: got %0d expected %0d", i, st_a, exp_st); end
      n_checks++;
    end
    if (fail_a !== 1'b0 || err_a !== 8'd0) begin n_fail++; $display("FAIL pass_verdict: fail %b err %0d expected 0 0", fail_a, err_a); end
    n_checks++;
    if (cc_a !== 8'd18) begin n_fail++; $display("FAIL pass_chk_a: got %0d expected 18", cc_a); end
    n_checks++;
    if (cc_b !== 3'd7) begin n_fail++; $display("FAIL pass_chk_b_sat: got %0d expected 7", cc_b); end
    n_checks++;
  endtask

  task automatic test_no_compare();
    step(2'b00, rnd(), prev_ref, 1, 1);
    step(2'b11, rnd(), ~prev_ref, 1, 1);
    step(2'b11, rnd(), prev_ref, 1, 1);
    if (err_a !== 8'd0 || err_b !== 3'd0) begin n_fail++; $display("FAIL nocond_err: got %0d/%0d expected 0/0", err_a, err_b); end
    n_checks++;
    if (cc_a !== 8'(exp_cc_a)) begin n_fail++; $display("FAIL nocond_chk: got %0d expected %0d", cc_a, exp_cc_a); end
    n_checks++;
    clr = 1'b1;
    step(2'b11, rnd(), ~prev_ref, 0, 0);
    clr = 1'b0;
    if (st_a !== 2'd1 || st_b !== 2'd1) begin n_fail++; $display("FAIL clr_warmup: got %0d/%0d expected 1/1", st_a, st_b); end
    n_checks++;
    step(2'b11, rnd(), ~prev_ref, 0, 0);
    step(2'b11, rnd(), ~prev_ref, 0, 0);
    if ({err_a, cc_a, err_b, cc_b, fail_a, fail_b} !== '0) begin
      n_fail++; $display("FAIL warmup_quiet: err/chk %0d %0d %0d %0d fail %b%b expected all 0", err_a, cc_a, err_b, cc_b, fail_a, fail_b);
    end
    n_checks++;
    if (st_a !== 2'd2) begin n_fail++; $display("FAIL warmup_exit: got %0d expected 2", st_a); end
    n_checks++;
  endtask

  task automatic test_first_fail();
    logic [9:0] r;
    r = rnd();
    step(2'b10, {5'h0A, r[4:0]}, prev_ref, 1, 1);
    step(2'b01, rnd(), {5'h0B, prev_ref[4:0]}, 1, 1);
    if ({fail_a, fch_a, fref_a, fdut_a, st_a} !== {1'b1, 3'd1, 5'h0A, 5'h0B, 2'd3}) begin
      n_fail++; $display("FAIL first_capture_a: fail %b chan %0d ref %h dut %h state %0d expected 1 1 0a 0b 3",
                         fail_a, fch_a, fref_a, fdut_a, st_a);
    end
    n_checks++;
    if ({fail_b, fch_b, fref_b, fdut_b, st_b} !== {1'b1, 3'd1, 5'h0A, 5'h0B, 2'd2}) begin
      n_fail++; $display("FAIL first_capture_b: fail %b chan %0d ref %h dut %h state %0d expected 1 1 0a 0b 2",
                         fail_b, fch_b, fref_b, fdut_b, st_b);
    end
    n_checks++;
    step(2'b01, rnd(), {prev_ref[9:5], ~prev_ref[4:0]}, 0, 1);
    step(2'b01, rnd(), prev_ref, 0, 1);
    if ({fch_b, fref_b, fdut_b} !== {3'd1, 5'h0A, 5'h0B}) begin
      n_fail++; $display("FAIL capture_kept_b: chan %0d ref %h dut %h expected 1 0a 0b", fch_b, fref_b, fdut_b);
    end
    n_checks++;
    if (err_a !== 8'(exp_err_a) || err_b !== 3'(exp_err_b)) begin
      n_fail++; $display("FAIL first_err: got %0d/%0d expected %0d/%0d", err_a, err_b, exp_err_a, exp_err_b);
    end
    n_checks++;
    if (st_a !== 2'd3 || cc_a !== 8'(exp_cc_a)) begin
      n_fail++; $display("FAIL halt_frozen: state %0d chk %0d expected 3 %0d", st_a, cc_a, exp_cc_a);
    end
    n_checks++;
  endtask

  task automatic test_clr_vs_mismatch();
    clr = 1'b1;
    step(2'b11, rnd(), {prev_ref[9:5], ~prev_ref[4:0]}, 0, 1);
    clr = 1'b0;
    if ({fail_a, fail_b, err_a, err_b, fch_b, fref_b, fdut_b} !== '0) begin
      n_fail++; $display("FAIL clr_wins: fail %b%b err %0d/%0d capture %0d %h %h expected all 0",
                         fail_a, fail_b, err_a, err_b, fch_b, fref_b, fdut_b);
    end
    n_checks++;
    if (st_a !== 2'd1 || st_b !== 2'd1) begin n_fail++; $display("FAIL clr_state: got %0d/%0d expected 1/1", st_a, st_b); end
    n_checks++;
    step(2'b11, rnd(), prev_ref, 0, 0);
    step(2'b11, rnd(), prev_ref, 0, 0);
  endtask

  task automatic test_both_fail();
    logic [9:0] pr;
    step(2'b11, rnd(), prev_ref, 1, 1);
    pr = prev_ref;
    step(2'b00, rnd(), ~pr, 1, 1);
    if (err_a !== 8'd2 || err_b !== 3'd2) begin n_fail++; $display("FAIL both_err: got %0d/%0d expected 2/2", err_a, err_b); end
    n_checks++;
    if ({fch_b, fref_b, fdut_b} !== {3'd0, pr[4:0], ~pr[4:0]}) begin
      n_fail++; $display("FAIL both_capture_b: chan %0d ref %h dut %h expected 0 %h %h", fch_b, fref_b, fdut_b, pr[4:0], ~pr[4:0]);
    end
    n_checks++;
    if (fch_a !== 3'd0 || st_a !== 2'd3) begin n_fail++; $display("FAIL both_a: chan %0d state %0d expected 0 3", fch_a, st_a); end
    n_checks++;
    step(2'b10, rnd(), prev_ref, 0, 1);
    step(2'b00, rnd(), {~prev_ref[9:5], prev_ref[4:0]}, 0, 1);
    if (err_b !== 3'd3 || {fch_b, fref_b} !== {3'd0, pr[4:0]}) begin
      n_fail++; $display("FAIL later_ch1_b: err %0d chan %0d ref %h expected 3 0 %h", err_b, fch_b, fref_b, pr[4:0]);
    end
    n_checks++;
  endtask

  task automatic test_saturate();
    clr = 1'b1;
    step(2'b01, rnd(), prev_ref, 0, 0);
    clr = 1'b0;
    step(2'b01, rnd(), prev_ref, 0, 0);
    step(2'b01, rnd(), prev_ref, 0, 0);
    for (int j = 0; j < 10; j++) step(2'b01, rnd(), {prev_ref[9:5], ~prev_ref[4:0]}, j == 0, 1);
    if (err_b !== 3'd7) begin n_fail++; $display("FAIL err_sat_b: got %0d expected 7", err_b); end
    n_checks++;
    if (err_a !== 8'd1 || st_a !== 2'd3) begin n_fail++; $display("FAIL sat_halt_a: err %0d state %0d expected 1 3", err_a, st_a); end
    n_checks++;
  endtask

  task automatic test_en_low();
    en = 1'b0;
    step(2'b01, rnd(), prev_ref, 0, 0);
    step(2'b01, rnd(), {prev_ref[9:5], ~prev_ref[4:0]}, 0, 0);
    if (st_a !== 2'd0 || st_b !== 2'd0) begin n_fail++; $display("FAIL idle_state: got %0d/%0d expected 0/0", st_a, st_b); end
    n_checks++;
    if (fail_a !== 1'b1 || err_a !== 8'(exp_err_a) || err_b !== 3'd7) begin
      n_fail++; $display("FAIL idle_hold: fail %b err %0d/%0d expected 1 %0d/7", fail_a, err_a, err_b, exp_err_a);
    end
    n_checks++;
  endtask

  task automatic test_async_rst();
    en = 1'b1;
    for (int k = 0; k < 3; k++) step(2'b01, rnd(), prev_ref, 0, 0);
    step(2'b01, rnd(), {prev_ref[9:5], ~prev_ref[4:0]}, 1, 1);
    #2 rst = 1'b1;
    #1;
    if ({st_a, mm_a, fail_a, fch_a, fref_a, fdut_a, err_a, cc_a} !== '0) begin
      n_fail++; $display("FAIL async_rst_a: got %h expected 0", {st_a, mm_a, fail_a, fch_a, fref_a, fdut_a, err_a, cc_a});
    end
    n_checks++;
    if ({st_b, mm_b, fail_b, fch_b, fref_b, fdut_b, err_b, cc_b} !== '0) begin
      n_fail++; $display("FAIL async_rst_b: got %h expected 0", {st_b, mm_b, fail_b, fch_b, fref_b, fdut_b, err_b, cc_b});
    end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_pass();
    test_no_compare();
    test_first_fail();
    test_clr_vs_mismatch();
    test_both_fail();
    test_saturate();
    test_en_low();
    test_async_rst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
